player_lives_tracker: RTL and testbench

Tracks the player tank's remaining lives and produces the `death` count consumed by the lives-bar display object. That object shrinks its bar by 20 px per death.
- Converts raw collision hits into counted deaths, with rising-edge detection.
- Runs a respawn delay and an invulnerability window in VGA frame units.
- Flags game over.
- Sits between the collision/hit logic and the HUD/tank-control blocks.

---
 rtl/lives_pkg.sv | 14 +
 rtl/edge_rise_detect.sv | 18 +
 rtl/player_lives_tracker.sv | 146 ++++++++++++++
 tb/tb_player_lives_tracker.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lives_pkg.sv
// rtl/lives_pkg.sv - shared state encoding and widths for the lives tracker
package lives_pkg;

  localparam int DEATH_W     = 2;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    RESPAWN   = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } lives_state_t;

endpackage

// File: rtl/edge_rise_detect.sv
// rtl/edge_rise_detect.sv - one-cycle rise pulse from a level input
module edge_rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (!resetN) in_q <= 1'b0;
    else         in_q <= in_i;
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/player_lives_tracker.sv
// rtl/player_lives_tracker.sv - death counter, respawn/invulnerability timer, game over flag
// Optional extra-life input is built only when LIVES_EXTRA_LIFE_EN is defined.
module player_lives_tracker
  import lives_pkg::*;
#(
  parameter int MAX_LIVES      = 3,
  parameter int RESPAWN_FRAMES = 30,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_BIT      = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hitEvent,
  input  logic               newGame,
`ifdef LIVES_EXTRA_LIFE_EN
  input  logic               bonusPickup,
`endif
  output logic [DEATH_W-1:0] death,
  output logic               gameOver,
  output logic               tankVisible,
  output logic               invulnerable,
  output logic               blink,
  output logic               respawnReq
);

  localparam logic [DEATH_W-1:0]     MAX_D   = DEATH_W'(MAX_LIVES);
  localparam logic [DEATH_W:0]       MAX_X   = (DEATH_W+1)'(MAX_LIVES);
  localparam logic [FRAME_CNT_W-1:0] RESP_LD = FRAME_CNT_W'(RESPAWN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] INV_LD  = FRAME_CNT_W'(INVULN_FRAMES);

  lives_state_t           state_q, state_d;
  logic [DEATH_W-1:0]     death_q, death_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic                   go_q, go_d;
  logic                   vis_q, vis_d;
  logic                   inv_q, inv_d;
  logic                   blink_q, blink_d;
  logic                   hit_rise;
  logic                   bonus_rise;

  edge_rise_detect u_hit_edge (
    .clk    (clk),
    .resetN (resetN),
    .in_i   (hitEvent),
    .rise_o (hit_rise)
  );

`ifdef LIVES_EXTRA_LIFE_EN
  edge_rise_detect u_bonus_edge (
    .clk    (clk),
    .resetN (resetN),
    .in_i   (bonusPickup),
    .rise_o (bonus_rise)
  );
`else
  assign bonus_rise = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= ALIVE;
      death_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      go_q    <= 1'b0;
      vis_q   <= 1'b1;
      inv_q   <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      death_q <= death_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      go_q    <= go_d;
      vis_q   <= vis_d;
      inv_q   <= inv_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    death_d = death_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    if (newGame) begin
      death_d = '0;
      cnt_d   = RESP_LD;
      state_d = RESPAWN;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit_rise) begin
            if ({1'b0, death_q} + 1'b1 >= MAX_X) begin
              death_d = MAX_D;
              state_d = GAME_OVER;
            end else begin
              death_d = death_q + 1'b1;
              cnt_d   = RESP_LD;
              state_d = RESPAWN;
            end
          end else if (bonus_rise && death_q != '0) begin
            death_d = death_q - 1'b1;
          end
        end
        RESPAWN: begin
          if (startOfFrame && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            // the decrement that lands on zero hands over to invulnerability
            if (cnt_q == FRAME_CNT_W'(1)) begin
              req_d   = 1'b1;
              cnt_d   = INV_LD;
              state_d = INVULN;
            end
          end
        end
        INVULN: begin
          if (bonus_rise && death_q != '0) death_d = death_q - 1'b1;
          if (startOfFrame && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == FRAME_CNT_W'(1)) state_d = ALIVE;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are derived from next state so they change on the same edge as the FSM
  always_comb begin
    go_d    = (state_d == GAME_OVER);
    vis_d   = !(state_d == RESPAWN || state_d == GAME_OVER);
    inv_d   = (state_d == RESPAWN || state_d == INVULN);
    blink_d = (state_d == INVULN) ? cnt_d[BLINK_BIT] : 1'b1;
  end

  assign death        = death_q;
  assign gameOver     = go_q;
  assign tankVisible  = vis_q;
  assign invulnerable = inv_q;
  assign blink        = blink_q;
  assign respawnReq   = req_q;

endmodule

// File: tb/tb_player_lives_tracker.sv
// tb/tb_player_lives_tracker.sv - table-driven scoreboard bench for player_lives_tracker
module tb_player_lives_tracker;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       hitEvent = 1'b0;
  logic       newGame = 1'b0;
  logic       bonusPickup = 1'b0;
  logic [1:0] death;
  logic       gameOver, tankVisible, invulnerable, blink, respawnReq;

  int n_tests = 0;
  int n_fail  = 0;

  player_lives_tracker #(
    .MAX_LIVES      (3),
    .RESPAWN_FRAMES (2),
    .INVULN_FRAMES  (3),
    .BLINK_BIT      (0)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hitEvent     (hitEvent),
    .newGame      (newGame),
`ifdef LIVES_EXTRA_LIFE_EN
    .bonusPickup  (bonusPickup),
`endif
    .death        (death),
    .gameOver     (gameOver),
    .tankVisible  (tankVisible),
    .invulnerable (invulnerable),
    .blink        (blink),
    .respawnReq   (respawnReq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n, sof, hit, ng, bonus;
    logic [1:0] death;
    logic       go, vis, inv, blk, req;
    logic       chk_all;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic r, s, h, n, b, input logic [1:0] d,
                              input logic g, vi, iv, bl, rq, ca);
    vec_t t;
    t = '{rst_n: r, sof: s, hit: h, ng: n, bonus: b, death: d,
          go: g, vis: vi, inv: iv, blk: bl, req: rq, chk_all: ca};
    return t;
  endfunction

  task automatic apply(input vec_t t, input string name);
    vec_t e;
    logic [6:0] got, want;
    resetN       = t.rst_n;
    startOfFrame = t.sof;
    hitEvent     = t.hit;
    newGame      = t.ng;
    bonusPickup  = t.bonus;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got  = {death, gameOver, tankVisible, invulnerable, blink, respawnReq};
    want = {e.death, e.go, e.vis, e.inv, e.blk, e.req};
    n_tests++;
    if (e.chk_all ? (got !== want) : (death !== e.death)) begin
      n_fail++;
      $display("FAIL %s: got {death,go,vis,inv,blink,req}=%b want %b (all=%0b)",
               name, got, want, e.chk_all);
    end
  endtask

  task automatic idle(input logic s, input int n);
    for (int k = 0; k < n; k++)
      apply(mk(1, s, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0), "idle");
  endtask

  initial begin
    //                r  s  h  n  b  death go vis inv blk req all
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 1)); // 0 reset
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0, 0, 1, 1, 0, 1)); // 1 first hit
    tbl.push_back(mk(1, 1, 1, 0, 0, 2'd1, 0, 0, 1, 1, 0, 1)); // 2 held, frame
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2'd1, 0, 1, 1, 1, 1, 1)); // 4 respawn pulse
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1, 0, 1, 1, 0, 0, 1)); // 6 blink low
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0, 1, 1, 0, 0, 1)); // 7 hit in invuln
    tbl.push_back(mk(1, 1, 1, 0, 0, 2'd1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2'd1, 0, 1, 0, 1, 0, 1)); // 9 alive, held hit
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'd1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2'd2, 0, 0, 1, 1, 0, 1)); // 12 hit with frame
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd2, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd2, 0, 1, 1, 1, 1, 1)); // 14
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd2, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd2, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd2, 0, 1, 0, 1, 0, 1)); // 17 alive
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd3, 1, 0, 0, 1, 0, 1)); // 18 game over
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'd3, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2'd3, 1, 0, 0, 1, 0, 1)); // 20 4th hit
    tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 1, 1, 0, 1)); // 21 new game
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, 0, 1, 1, 1, 1, 1)); // 23
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 1, 1, 0, 1)); // 25 new game
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 1)); // 27 reset mid respawn
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // hit held 500 cycles across three frames counts once
    apply(mk(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 1), "hold_reset");
    apply(mk(1, 0, 1, 0, 0, 2'd1, 0, 0, 1, 1, 0, 1), "hold_rise");
    for (int i = 1; i < 500; i++)
      apply(mk(1, (i % 150) == 149, 1, 0, 0, 2'd1, 0, 0, 0, 0, 0, 0), "hold_death");

`ifdef LIVES_EXTRA_LIFE_EN
    apply(mk(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 1), "xl_reset");
    apply(mk(1, 0, 1, 0, 0, 2'd1, 0, 0, 1, 1, 0, 1), "xl_hit1");
    idle(1, 5);
    apply(mk(1, 0, 1, 0, 0, 2'd2, 0, 0, 1, 1, 0, 1), "xl_hit2");
    idle(1, 5);
    apply(mk(1, 0, 0, 0, 0, 2'd2, 0, 1, 0, 1, 0, 1), "xl_alive2");
    apply(mk(1, 0, 0, 0, 1, 2'd1, 0, 1, 0, 1, 0, 1), "xl_bonus_2to1");
    apply(mk(1, 0, 0, 0, 0, 2'd1, 0, 1, 0, 1, 0, 1), "xl_low");
    apply(mk(1, 0, 0, 0, 1, 2'd0, 0, 1, 0, 1, 0, 1), "xl_bonus_1to0");
    apply(mk(1, 0, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 1), "xl_low2");
    apply(mk(1, 0, 0, 0, 1, 2'd0, 0, 1, 0, 1, 0, 1), "xl_bonus_at0");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
